load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the 256-byte data memory port. Accepts byte and 16-bit halfword load/store requests from the core over a valid/ready handshake. Sequences them into single-byte memory accesses on the memory's write/address/datain/dataout port, assembles little-endian read data, and returns one response per request over a second valid/ready handshake. Sits between the core's execute stage and the data memory.

## Interface
- ADDR_W, 8, memory address width (256 locations)
- DATA_W, 8, memory data width (one byte per location)
- clk  in  1  system clock; all state in this block changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at posedge
- req_write  in  1  1 = store, 0 = load
- req_half  in  1  1 = halfword (2 bytes), 0 = byte
- req_addr  in  ADDR_W  byte address of low byte
- req_wdata  in  2*DATA_W  store data; [7:0] goes to addr, [15:8] goes to addr+1
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at posedge
- rsp_rdata  out  2*DATA_W  load data; zero for stores; [15:8] zero for byte loads
- mem_write  out  1  memory write enable
- mem_address  out  ADDR_W  memory address
- mem_datain  out  DATA_W  memory write data
- mem_dataout  in  DATA_W  memory read data, valid after the negedge following a read address

## Operation
- FSM states: IDLE, BYTE0, BYTE1, RESP.
- req_ready = (state==IDLE) || (state==RESP && rsp_ready). It is combinational from state and rsp_ready only.
- **Accept.** Latch write, half, addr, and wdata. Drive mem_address=addr and mem_write=req_write. If a store, drive mem_datain=wdata[7:0]. Go to BYTE0.
- **BYTE0.**
  - For loads, capture mem_dataout into rdata[7:0].
  - For a halfword, drive mem_address=(addr+1) mod 256, so 0xFF wraps to 0x00. For halfword stores, also drive mem_write=1 and mem_datain=wdata[15:8]. Go to BYTE1.
  - For a byte access, drive mem_write=0, set rsp_valid=1, and go to RESP.
- **BYTE1.** For loads, capture mem_dataout into rdata[15:8]. Drive mem_write=0, set rsp_valid=1, and go to RESP.
- **RESP.** Hold rsp_valid and rsp_rdata stable until the response handshake completes.
  - If a new request is accepted in the same cycle, follow the Accept rules and go to BYTE0.
  - Otherwise clear rsp_valid and go to IDLE.
- mem_write is 1 only in the cycle immediately after a store is accepted, and in BYTE0 of a halfword store. It is 0 in every other cycle.
- mem_address and mem_datain hold their last value when idle.
- Misaligned halfwords are legal. There is no alignment error.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, mem_write=0, mem_address=0, mem_datain=0.
- Asserting reset_n low mid-operation clears mem_write immediately (asynchronously). A write whose memory negedge has not yet occurred is aborted. A halfword store may be left half-written; this is acceptable.
- Memory samples on negedge, so the address and write data driven after posedge T are used at the negedge inside cycle T. Read data is sampled at posedge T+1.
- Latency from request acceptance (posedge T0) to rsp_valid high:
  - byte load or store: visible after posedge T0+1
  - halfword load or store: visible after posedge T0+2
- With rsp_ready held at 1, throughput is one byte op per 2 cycles and one halfword op per 3 cycles.
- While a response is stalled (rsp_ready=0), no memory write occurs and req_ready=0.

## Structure
- Shared package lsu_pkg:
  - state typedef (IDLE/BYTE0/BYTE1/RESP)
  - ADDR_W and DATA_W defaults
  - HALF_W = 2*DATA_W
- No sub-module; the address incrementer and byte steering are inline.
- The bench instantiates this block against the existing 256-byte data memory, on the same clk.

## Test plan
- Reset then idle: reset_n low for 3 cycles, then high -> req_ready=1, rsp_valid=0, mem_write=0, all outputs 0.
- Byte store then load: store 0xA5 at 0x10, then load 0x10 -> mem_write high for exactly one cycle; load rsp_rdata=0x00A5 one cycle after acceptance.
- Halfword wrap: store 0xBEEF at 0xFF, then halfword load at 0xFF -> memory[0xFF]=0xEF and memory[0x00]=0xBE; rsp_rdata=0xBEEF two cycles after acceptance.
- Backpressure: hold rsp_ready=0 for 4 cycles with req_valid=1 -> rsp_valid and rsp_rdata stable, req_ready=0, no mem_write. Then rsp_ready=1 -> new request accepted in the same cycle as the response handshake.
- Back-to-back: 8 byte loads of 0x00..0x07 with rsp_ready=1 -> 8 responses, one every 2 cycles, in order, with correct data.
- Reset mid-store: assert reset_n low right after accepting a halfword store of 0x1234 at 0x20 -> mem_write falls immediately, memory[0x21] unchanged, FSM in IDLE after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and widths for the load/store unit
// and the data memory port it drives.
package lsu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int HALF_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    BYTE0,
    BYTE1,
    RESP
  } state_t;

endpackage

// File: rtl/load_store_unit.sv
// Byte/halfword load-store sequencer onto a
// single-byte negedge-sampled data memory port.
module load_store_unit #(
  parameter int ADDR_W = lsu_pkg::ADDR_W,
  parameter int DATA_W = lsu_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_half,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_rdata,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_datain,
  input  logic [DATA_W-1:0]   mem_dataout
);

  import lsu_pkg::*;

  localparam int HW = 2 * DATA_W;

  state_t            state;
  logic              wr;
  logic              half;
  logic [ADDR_W-1:0] addr;
  logic [HW-1:0]     wdata;
  logic              accept;

  assign req_ready = (state == IDLE) ||
                     (state == RESP && rsp_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_datain  <= '0;
      wr          <= 1'b0;
      half        <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
    end else if (accept) begin
      // Also the RESP handshake cycle: the old
      // response retires as the new one starts.
      wr          <= req_write;
      half        <= req_half;
      addr        <= req_addr;
      wdata       <= req_wdata;
      mem_address <= req_addr;
      mem_write   <= req_write;
      if (req_write)
        mem_datain <= req_wdata[DATA_W-1:0];
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      state       <= BYTE0;
    end else begin
      unique case (state)
        BYTE0: begin
          if (!wr)
            rsp_rdata[DATA_W-1:0] <= mem_dataout;
          if (half) begin
            mem_address <= addr + ADDR_W'(1);
            mem_write   <= wr;
            if (wr)
              mem_datain <= wdata[HW-1:DATA_W];
            state <= BYTE1;
          end else begin
            mem_write <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        BYTE1: begin
          if (!wr)
            rsp_rdata[HW-1:DATA_W] <= mem_dataout;
          mem_write <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a
// 256-byte negedge-sampled data memory model.
module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_half;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        mem_write;
  logic [7:0]  mem_address;
  logic [7:0]  mem_datain;
  logic [7:0]  mem_dataout;
  logic        init_mem;

  logic [7:0]  mem [256];

  int vectors;
  int errors;

  load_store_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_half    (req_half),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_datain  (mem_datain),
    .mem_dataout (mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory preloads mem[i] = 0x60 + i while init_mem is high.
  always @(negedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= 8'(8'h60 + i);
    end else if (mem_write) begin
      mem[mem_address] <= mem_datain;
    end
    mem_dataout <= mem[mem_address];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic h,
                       input logic [7:0] a,
                       input logic [15:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_half  = h;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    init_mem = 1'b1;
    repeat (3) step();
    reset_n  = 1'b1;
    init_mem = 1'b0;
    step();
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_req_ready got %b exp 1", req_ready);
    end
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0) begin
      errors++;
      $display("FAIL rst_rsp got %b/%h exp 0/0000",
               rsp_valid, rsp_rdata);
    end
    vectors++;
    if (mem_write !== 1'b0 || mem_address !== 8'h00 ||
        mem_datain !== 8'h00) begin
      errors++;
      $display("FAIL rst_mem got %b/%h/%h exp 0/00/00",
               mem_write, mem_address, mem_datain);
    end
  endtask

  task automatic test_byte_store_load;
    drive(1'b1, 1'b0, 8'h10, 16'h33A5);
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bst_ready got %b exp 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    vectors++;
    if (mem_write !== 1'b1 || mem_address !== 8'h10 ||
        mem_datain !== 8'hA5) begin
      errors++;
      $display("FAIL bst_mem got %b/%h/%h exp 1/10/a5",
               mem_write, mem_address, mem_datain);
    end
    step();
    vectors++;
    if (mem_write !== 1'b0 || rsp_valid !== 1'b1 ||
        rsp_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL bst_rsp got we=%b v=%b d=%h exp 0/1/0000",
               mem_write, rsp_valid, rsp_rdata);
    end
    vectors++;
    if (mem[8'h10] !== 8'hA5) begin
      errors++;
      $display("FAIL bst_array got %h exp a5", mem[8'h10]);
    end
    step();
    drive(1'b0, 1'b0, 8'h10, 16'h0000);
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bst_idle got v=%b r=%b exp 0/1",
               rsp_valid, req_ready);
    end
    step();
    req_valid = 1'b0;
    vectors++;
    if (mem_write !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bld_t0 got we=%b v=%b exp 0/0",
               mem_write, rsp_valid);
    end
    step();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h00A5) begin
      errors++;
      $display("FAIL bld_rsp got %b/%h exp 1/00a5",
               rsp_valid, rsp_rdata);
    end
    step();
  endtask

  task automatic test_half_wrap;
    drive(1'b1, 1'b1, 8'hFF, 16'hBEEF);
    step();
    req_valid = 1'b0;
    vectors++;
    if (mem_write !== 1'b1 || mem_address !== 8'hFF ||
        mem_datain !== 8'hEF) begin
      errors++;
      $display("FAIL hst_b0 got %b/%h/%h exp 1/ff/ef",
               mem_write, mem_address, mem_datain);
    end
    step();
    vectors++;
    if (mem_write !== 1'b1 || mem_address !== 8'h00 ||
        mem_datain !== 8'hBE || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hst_b1 got %b/%h/%h v=%b exp 1/00/be v=0",
               mem_write, mem_address, mem_datain, rsp_valid);
    end
    step();
    vectors++;
    if (mem_write !== 1'b0 || rsp_valid !== 1'b1 ||
        rsp_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL hst_rsp got we=%b v=%b d=%h exp 0/1/0000",
               mem_write, rsp_valid, rsp_rdata);
    end
    vectors++;
    if (mem[8'hFF] !== 8'hEF || mem[8'h00] !== 8'hBE) begin
      errors++;
      $display("FAIL hst_array got ff=%h 00=%h exp ef/be",
               mem[8'hFF], mem[8'h00]);
    end
    step();
    drive(1'b0, 1'b1, 8'hFF, 16'h0000);
    step();
    req_valid = 1'b0;
    step();
    vectors++;
    if (rsp_valid !== 1'b0 || mem_address !== 8'h00) begin
      errors++;
      $display("FAIL hld_b0 got v=%b a=%h exp 0/00",
               rsp_valid, mem_address);
    end
    step();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL hld_rsp got %b/%h exp 1/beef",
               rsp_valid, rsp_rdata);
    end
    step();
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h11, 16'h0000);
    step();
    req_valid = 1'b0;
    step();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0071) begin
      errors++;
      $display("FAIL bp_first got %b/%h exp 1/0071",
               rsp_valid, rsp_rdata);
    end
    drive(1'b1, 1'b0, 8'h12, 16'h00C3);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0071 ||
          req_ready !== 1'b0 || mem_write !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%h r=%b we=%b exp 1/0071/0/0",
                 i, rsp_valid, rsp_rdata, req_ready, mem_write);
      end
      step();
    end
    drive(1'b0, 1'b0, 8'h12, 16'h0000);
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got %b exp 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || mem_address !== 8'h12) begin
      errors++;
      $display("FAIL bp_accept got v=%b a=%h exp 0/12",
               rsp_valid, mem_address);
    end
    step();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0072) begin
      errors++;
      $display("FAIL bp_second got %b/%h exp 1/0072",
               rsp_valid, rsp_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_data [8];
    int n_req;
    int n_rsp;
    int last_cyc;
    logic acc;
    logic hs;
    exp_data[0] = 16'h00BE;
    for (int i = 1; i < 8; i++)
      exp_data[i] = 16'(16'h0060 + i);
    n_req    = 0;
    n_rsp    = 0;
    last_cyc = 0;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 16'h0000);
    for (int cyc = 0; cyc < 40 && n_rsp < 8; cyc++) begin
      acc = req_valid && req_ready;
      hs  = rsp_valid && rsp_ready;
      step();
      if (hs) begin
        if (n_rsp > 0) begin
          vectors++;
          if (cyc - last_cyc !== 2) begin
            errors++;
            $display("FAIL b2b_gap%0d got %0d exp 2",
                     n_rsp, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        n_rsp++;
      end
      if (acc) begin
        n_req++;
        if (n_req == 8)
          req_valid = 1'b0;
        else
          req_addr = 8'(n_req);
      end
      if (rsp_valid === 1'b1) begin
        vectors++;
        if (rsp_rdata !== exp_data[n_rsp]) begin
          errors++;
          $display("FAIL b2b_data%0d got %h exp %h",
                   n_rsp, rsp_rdata, exp_data[n_rsp]);
        end
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (n_rsp !== 8) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 8", n_rsp);
    end
    step();
  endtask

  task automatic test_reset_mid_store;
    drive(1'b1, 1'b1, 8'h20, 16'h1234);
    step();
    req_valid = 1'b0;
    vectors++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL rms_we_pre got %b exp 1", mem_write);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (mem_write !== 1'b0) begin
      errors++;
      $display("FAIL rms_we_async got %b exp 0", mem_write);
    end
    repeat (2) step();
    reset_n = 1'b1;
    step();
    vectors++;
    if (mem[8'h21] !== 8'h81 || mem[8'h20] !== 8'h80) begin
      errors++;
      $display("FAIL rms_array got 20=%h 21=%h exp 80/81",
               mem[8'h20], mem[8'h21]);
    end
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        mem_write !== 1'b0) begin
      errors++;
      $display("FAIL rms_idle got r=%b v=%b we=%b exp 1/0/0",
               req_ready, rsp_valid, mem_write);
    end
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    reset_n   = 1'b0;
    init_mem  = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_half  = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
    rsp_ready = 1'b1;
    #1;
    test_reset();
    test_byte_store_load();
    test_half_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
